// File: rtl/pipeline_interlock.sv
// Hazard/interlock controller beside the forwarding unit: stalls DECODE on load-use,
// a second load while one is outstanding, and HI/LO access while mul/div is busy.
module pipeline_interlock #(
   parameter int MULDIV_LATENCY = 32,
   parameter int CNT_W          = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs_index,
   input  logic [4:0]  dec_rt_index,
   input  logic        dec_uses_rs,
   input  logic        dec_uses_rt,
   input  logic        dec_is_load,
   input  logic        dec_is_muldiv,
   input  logic        dec_reads_hilo,
   input  logic        alu_valid,
   input  logic        alu_is_load,
   input  logic [4:0]  alu_rd_index,
   input  logic        mem_load_done,
   input  logic        branch_taken,
   output logic        stall,
   output logic        bubble,
   output logic        flush,
   output logic        muldiv_busy,
   output logic        load_pending,
   output logic [4:0]  pending_index,
   output logic [31:0] stall_count
);

   localparam logic [0:0]       L_IDLE = 1'b0;
   localparam logic [0:0]       L_WAIT = 1'b1;
   localparam logic [CNT_W-1:0] MD_LAT = CNT_W'(MULDIV_LATENCY);

   logic [0:0]       lstate_q, lstate_d;
   logic [4:0]       pending_q, pending_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [31:0]      count_q, count_d;

   logic alu_load_s, wait_open_s;
   logic h_alu_load, h_wait, h_struct_load, h_md;
   logic stall_s, flush_s, issue_s;

   // Register 0 is hardwired to zero, so it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] x, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic use_rs,
                                      input logic use_rt);
      reg_match = (use_rs & (rs != 5'd0) & (rs == x)) |
                  (use_rt & (rt != 5'd0) & (rt == x));
   endfunction

   always_comb begin
      alu_load_s    = alu_valid & alu_is_load & (alu_rd_index != 5'd0);
      wait_open_s   = (lstate_q == L_WAIT) & ~mem_load_done;
      h_alu_load    = dec_valid & alu_load_s &
                      reg_match(alu_rd_index, dec_rs_index, dec_rt_index, dec_uses_rs, dec_uses_rt);
      // The done cycle releases: data arrives on the forwarding path that cycle.
      h_wait        = dec_valid & wait_open_s &
                      reg_match(pending_q, dec_rs_index, dec_rt_index, dec_uses_rs, dec_uses_rt);
      h_struct_load = dec_valid & dec_is_load & (wait_open_s | alu_load_s);
      h_md          = dec_valid & (md_cnt_q != '0) & (dec_is_muldiv | dec_reads_hilo);
      flush_s       = ~rst & branch_taken;
      stall_s       = ~rst & ~branch_taken & (h_alu_load | h_wait | h_struct_load | h_md);
      issue_s       = dec_valid & dec_is_muldiv & ~stall_s & ~flush_s;
   end

   always_comb begin
      lstate_d  = lstate_q;
      pending_d = pending_q;
      case (lstate_q)
         L_IDLE: begin
            if (alu_load_s) begin
               lstate_d  = L_WAIT;
               pending_d = alu_rd_index;
            end else begin
               lstate_d  = L_IDLE;
            end
         end
         L_WAIT: begin
            if (mem_load_done) begin
               lstate_d  = L_IDLE;
               pending_d = 5'd0;
            end else begin
               lstate_d  = L_WAIT;
            end
         end
         default: begin
            lstate_d  = L_IDLE;
            pending_d = 5'd0;
         end
      endcase
   end

   // A flush never cancels a running mul/div; only a new issue reloads it.
   always_comb begin
      if (issue_s) begin
         md_cnt_d = MD_LAT;
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         md_cnt_d = md_cnt_q;
      end
      if (stall_s && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lstate_q  <= L_IDLE;
         pending_q <= 5'd0;
         md_cnt_q  <= '0;
         count_q   <= 32'd0;
      end else begin
         lstate_q  <= lstate_d;
         pending_q <= pending_d;
         md_cnt_q  <= md_cnt_d;
         count_q   <= count_d;
      end
   end

   assign stall         = stall_s;
   assign bubble        = stall_s;
   assign flush         = flush_s;
   assign muldiv_busy   = (md_cnt_q != '0);
   assign load_pending  = (lstate_q == L_WAIT);
   assign pending_index = pending_q;
   assign stall_count   = count_q;

endmodule

// File: tb/tb_pipeline_interlock.sv
// Directed bench for pipeline_interlock: load-use, $0 loads, structural load hazard,
// mul/div busy, flush priority, mid-operation reset and stall counter saturation.
module tb_pipeline_interlock;

   logic        clk;
   logic        rst;
   logic        dec_valid;
   logic [4:0]  dec_rs_index;
   logic [4:0]  dec_rt_index;
   logic        dec_uses_rs;
   logic        dec_uses_rt;
   logic        dec_is_load;
   logic        dec_is_muldiv;
   logic        dec_reads_hilo;
   logic        alu_valid;
   logic        alu_is_load;
   logic [4:0]  alu_rd_index;
   logic        mem_load_done;
   logic        branch_taken;
   logic        stall;
   logic        bubble;
   logic        flush;
   logic        muldiv_busy;
   logic        load_pending;
   logic [4:0]  pending_index;
   logic [31:0] stall_count;

   int checks   = 0;
   int failures = 0;

   pipeline_interlock #(.MULDIV_LATENCY(4), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_rs_index(dec_rs_index), .dec_rt_index(dec_rt_index),
      .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_is_load(dec_is_load),
      .dec_is_muldiv(dec_is_muldiv), .dec_reads_hilo(dec_reads_hilo),
      .alu_valid(alu_valid), .alu_is_load(alu_is_load), .alu_rd_index(alu_rd_index),
      .mem_load_done(mem_load_done), .branch_taken(branch_taken),
      .stall(stall), .bubble(bubble), .flush(flush), .muldiv_busy(muldiv_busy),
      .load_pending(load_pending), .pending_index(pending_index), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      dec_valid = 1'b0; dec_rs_index = 5'd0; dec_rt_index = 5'd0;
      dec_uses_rs = 1'b0; dec_uses_rt = 1'b0; dec_is_load = 1'b0;
      dec_is_muldiv = 1'b0; dec_reads_hilo = 1'b0;
      alu_valid = 1'b0; alu_is_load = 1'b0; alu_rd_index = 5'd0;
      mem_load_done = 1'b0; branch_taken = 1'b0;
   endtask

   initial begin
      clr();
      rst = 1'b1;
      // Reset state
      tick(); tick();
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_count", stall_count, 32'd0);
      check("rst_load_pending", {31'd0, load_pending}, 32'd0);
      check("rst_pending_index", {27'd0, pending_index}, 32'd0);
      check("rst_busy", {31'd0, muldiv_busy}, 32'd0);
      rst = 1'b0;
      tick();

      // Load-use on $5, data returns three cycles later
      alu_valid = 1'b1; alu_is_load = 1'b1; alu_rd_index = 5'd5;
      dec_valid = 1'b1; dec_rs_index = 5'd5; dec_uses_rs = 1'b1;
      #1;
      check("lu_c0_stall", {31'd0, stall}, 32'd1);
      check("lu_c0_bubble", {31'd0, bubble}, 32'd1);
      tick();
      alu_valid = 1'b0; alu_is_load = 1'b0; alu_rd_index = 5'd0;
      #1;
      check("lu_c1_pending", {31'd0, load_pending}, 32'd1);
      check("lu_c1_index", {27'd0, pending_index}, 32'd5);
      check("lu_c1_stall", {31'd0, stall}, 32'd1);
      tick();
      check("lu_c2_stall", {31'd0, stall}, 32'd1);
      tick();
      mem_load_done = 1'b1;
      #1;
      check("lu_done_stall", {31'd0, stall}, 32'd0);
      check("lu_done_bubble", {31'd0, bubble}, 32'd0);
      tick();
      clr();
      #1;
      check("lu_after_pending", {31'd0, load_pending}, 32'd0);
      check("lu_after_index", {27'd0, pending_index}, 32'd0);
      check("lu_count", stall_count, 32'd3);

      // Load to $0 never creates a hazard nor an outstanding load
      alu_valid = 1'b1; alu_is_load = 1'b1; alu_rd_index = 5'd0;
      dec_valid = 1'b1; dec_rs_index = 5'd0; dec_uses_rs = 1'b1;
      #1;
      check("r0_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      #1;
      check("r0_pending", {31'd0, load_pending}, 32'd0);
      check("r0_count", stall_count, 32'd3);

      // Structural hazard: second load while $7 is outstanding
      alu_valid = 1'b1; alu_is_load = 1'b1; alu_rd_index = 5'd7;
      #1;
      check("st_issue_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      dec_valid = 1'b1; dec_is_load = 1'b1;
      dec_rs_index = 5'd1; dec_rt_index = 5'd2; dec_uses_rs = 1'b1; dec_uses_rt = 1'b1;
      #1;
      check("st_index", {27'd0, pending_index}, 32'd7);
      check("st_c0_stall", {31'd0, stall}, 32'd1);
      tick();
      check("st_c1_stall", {31'd0, stall}, 32'd1);
      tick();
      clr();
      dec_valid = 1'b1; dec_rs_index = 5'd3; dec_uses_rs = 1'b1;
      #1;
      check("st_indep_stall", {31'd0, stall}, 32'd0);
      tick();
      dec_rs_index = 5'd7;
      #1;
      check("st_dep_stall", {31'd0, stall}, 32'd1);
      tick();
      mem_load_done = 1'b1;
      #1;
      check("st_done_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      #1;
      check("st_after_pending", {31'd0, load_pending}, 32'd0);
      check("st_count", stall_count, 32'd6);

      // mult issues, mflo waits exactly MULDIV_LATENCY=4 cycles
      dec_valid = 1'b1; dec_is_muldiv = 1'b1;
      #1;
      check("md_issue_stall", {31'd0, stall}, 32'd0);
      check("md_issue_busy", {31'd0, muldiv_busy}, 32'd0);
      tick();
      dec_is_muldiv = 1'b0; dec_reads_hilo = 1'b1;
      #1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("md_c%0d_busy", i), {31'd0, muldiv_busy}, 32'd1);
         check($sformatf("md_c%0d_stall", i), {31'd0, stall}, 32'd1);
         tick();
      end
      check("md_c5_busy", {31'd0, muldiv_busy}, 32'd0);
      check("md_c5_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      #1;
      check("md_count", stall_count, 32'd10);

      // Taken branch overrides a pending load-use stall and blocks a mult issue
      alu_valid = 1'b1; alu_is_load = 1'b1; alu_rd_index = 5'd9;
      tick();
      clr();
      dec_valid = 1'b1; dec_rs_index = 5'd9; dec_uses_rs = 1'b1; dec_is_muldiv = 1'b1;
      branch_taken = 1'b1;
      #1;
      check("fl_flush", {31'd0, flush}, 32'd1);
      check("fl_stall", {31'd0, stall}, 32'd0);
      check("fl_bubble", {31'd0, bubble}, 32'd0);
      tick();
      clr();
      #1;
      check("fl_pending", {31'd0, load_pending}, 32'd1);
      check("fl_index", {27'd0, pending_index}, 32'd9);
      check("fl_busy", {31'd0, muldiv_busy}, 32'd0);
      check("fl_count", stall_count, 32'd10);

      // Reset while a load and a mul/div are both in flight
      dec_valid = 1'b1; dec_is_muldiv = 1'b1;
      #1;
      check("rm_issue_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      #1;
      check("rm_busy_before", {31'd0, muldiv_busy}, 32'd1);
      check("rm_pending_before", {31'd0, load_pending}, 32'd1);
      rst = 1'b1;
      dec_valid = 1'b1; dec_rs_index = 5'd9; dec_uses_rs = 1'b1; branch_taken = 1'b1;
      #1;
      check("rm_stall_forced", {31'd0, stall}, 32'd0);
      check("rm_flush_forced", {31'd0, flush}, 32'd0);
      check("rm_bubble_forced", {31'd0, bubble}, 32'd0);
      tick();
      rst = 1'b0;
      clr();
      #1;
      check("rm_pending", {31'd0, load_pending}, 32'd0);
      check("rm_index", {27'd0, pending_index}, 32'd0);
      check("rm_busy", {31'd0, muldiv_busy}, 32'd0);
      check("rm_count", stall_count, 32'd0);
      mem_load_done = 1'b1;
      tick();
      clr();
      #1;
      check("rm_stale_done", {31'd0, load_pending}, 32'd0);

      // Saturation of the stall counter
      alu_valid = 1'b1; alu_is_load = 1'b1; alu_rd_index = 5'd4;
      dec_valid = 1'b1; dec_rs_index = 5'd4; dec_uses_rs = 1'b1;
      #1;
      check("sat_stall", {31'd0, stall}, 32'd1);
      force dut.count_q = 32'hFFFF_FFFF;
      tick();
      release dut.count_q;
      alu_valid = 1'b0; alu_is_load = 1'b0; alu_rd_index = 5'd0;
      #1;
      check("sat_wait_stall", {31'd0, stall}, 32'd1);
      check("sat_c0", stall_count, 32'hFFFF_FFFF);
      tick();
      check("sat_c1", stall_count, 32'hFFFF_FFFF);
      tick();
      check("sat_c2", stall_count, 32'hFFFF_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_interlock.md
Name: pipeline_interlock

Overview:
- Hazard/interlock controller for the 5-stage integer pipeline; sits beside the operand forwarding unit, between DECODE and ALU.
- Covers the cases forwarding cannot resolve: load-use dependencies, a single outstanding load, and busy multi-cycle mul/div (HI/LO).
- Drives stall (hold FETCH/DECODE), bubble (inject NOP into ALU) and flush (discard wrong-path DECODE on taken branch). Also keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_LATENCY, 32, cycles from mul/div issue until HI/LO valid (1..2^CNT_W-1)
CNT_W, 6, width of the mul/div countdown counter

Ports:
clk  in  1  clock
rst  in  1  reset
dec_valid  in  1  DECODE holds a valid instruction
dec_rs_index  in  5  DECODE source rs
dec_rt_index  in  5  DECODE source rt
dec_uses_rs  in  1  instruction reads rs
dec_uses_rt  in  1  instruction reads rt
dec_is_load  in  1  DECODE instruction is a load
dec_is_muldiv  in  1  DECODE instruction is mult/multu/div/divu
dec_reads_hilo  in  1  DECODE instruction is mfhi/mflo
alu_valid  in  1  ALU stage holds a valid instruction
alu_is_load  in  1  ALU instruction is a load
alu_rd_index  in  5  ALU instruction destination
mem_load_done  in  1  memory returns data for the outstanding load this cycle
branch_taken  in  1  ALU resolved a taken branch/jump this cycle
stall  out  1  hold PC and DECODE register
bubble  out  1  replace ALU input with NOP
flush  out  1  invalidate DECODE instruction
muldiv_busy  out  1  HI/LO not yet valid
load_pending  out  1  one load outstanding
pending_index  out  5  destination of outstanding load
stall_count  out  32  saturating count of stalled cycles

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset: load FSM=L_IDLE, pending_index=0, mul/div counter=0, stall_count=0. While rst=1, stall/bubble/flush are forced 0.
- Match(x): (dec_uses_rs & rs!=0 & rs==x) | (dec_uses_rt & rt!=0 & rt==x). Register 0 never matches.
- Load FSM states L_IDLE and L_WAIT.
  - L_IDLE -> L_WAIT on alu_valid & alu_is_load & alu_rd_index!=0. At the same edge, pending_index <= alu_rd_index.
  - L_WAIT -> L_IDLE on mem_load_done. At the same edge, pending_index <= 0.
  - mem_load_done is ignored in L_IDLE.
  - A load with destination 0 never enters L_WAIT.
- Hazards (combinational), all qualified by dec_valid:
  - h_alu_load = alu_valid & alu_is_load & alu_rd_index!=0 & Match(alu_rd_index).
  - h_wait = L_WAIT & !mem_load_done & Match(pending_index). Release happens in the done cycle because data arrives on the forwarding path that cycle.
  - h_struct_load = dec_is_load & ((L_WAIT & !mem_load_done) | (alu_valid & alu_is_load & alu_rd_index!=0)). Only one load may be outstanding.
  - h_md = muldiv_busy & (dec_is_muldiv | dec_reads_hilo).
- Output equations:
  - flush = branch_taken.
  - stall = !flush & (h_alu_load | h_wait | h_struct_load | h_md).
  - bubble = stall.
  - Flush has priority: a wrong-path instruction is never stalled.
- Mul/div counter:
  - Issue = dec_valid & dec_is_muldiv & !stall & !flush. Issue loads the counter with MULDIV_LATENCY at the next edge.
  - Otherwise the counter decrements while nonzero.
  - muldiv_busy = counter!=0, so busy lasts exactly MULDIV_LATENCY cycles after the issue cycle.
  - A flush does not cancel an already-running operation.
- Flush does not affect an outstanding load: the load is older than the branch.
- stall_count increments by 1 on each edge where stall=1. It holds at 0xFFFFFFFF.
- Reset mid-operation abandons the outstanding load and the mul/div countdown immediately. Any later mem_load_done for the abandoned load is ignored because the FSM is in L_IDLE.

Test Plan:
- lw $5 in ALU (alu_rd_index=5); DECODE addu reads rs=5; mem_load_done asserted 3 cycles later -> stall=bubble=1 for 3 cycles, then 0 in the done cycle; load_pending 1->0; stall_count=3.
- Load to $0 in ALU; DECODE reads rs=0 -> stall=0, load_pending stays 0.
- L_WAIT pending_index=7; DECODE is a load with unrelated regs -> stall until mem_load_done; independent ALU op (rs=3) -> stall=0.
- MULDIV_LATENCY=4; mult issued at cycle 0; mflo in DECODE at cycle 1 -> stall cycles 1-4, mflo proceeds at cycle 5; muldiv_busy high cycles 1-4.
- branch_taken=1 while h_wait is true -> flush=1, stall=0, bubble=0; load_pending unchanged; a mult in DECODE that cycle does not start the counter.
- rst asserted in L_WAIT with counter=10 -> next cycle load_pending=0, pending_index=0, muldiv_busy=0, stall_count=0. Then force stall_count to 0xFFFFFFFF and hold a stall -> count stays 0xFFFFFFFF.
